// File: rtl/kv_pkg.sv
// rtl/kv_pkg.sv - shared KV descriptor fields, header layout and opcode/status codes
package kv_pkg;

  localparam logic [7:0]  OP_SET    = 8'h01;
  localparam logic [7:0]  OP_GET    = 8'h02;

  localparam logic [7:0]  ST_HIT    = 8'h00;
  localparam logic [7:0]  ST_MISS   = 8'h01;

  localparam logic [15:0] MAGIC     = 16'hFFFF;
  localparam int          HDR_BYTES = 16;

  // Header bit offsets inside the 128-bit request/response header
  localparam int HDR_NET_LSB    = 64;
  localparam int HDR_OP_LSB     = 56;
  localparam int HDR_STATUS_LSB = 48;
  localparam int HDR_TOTLEN_LSB = 32;
  localparam int HDR_MAGIC_LSB  = 0;

  // Descriptor layout shared with the request parser (MSB first)
  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  keylen;
    logic [15:0] vallen;
    logic [63:0] net_meta;
  } kv_meta_t;

  // Response header: totlen reports the value length only for a GET that hit
  function automatic logic [127:0] build_header(input kv_meta_t m, input logic hit);
    logic [127:0] h;
    h = '0;
    h[HDR_NET_LSB +: 64]    = m.net_meta;
    h[HDR_OP_LSB +: 8]      = m.opcode;
    h[HDR_STATUS_LSB +: 8]  = hit ? ST_HIT : ST_MISS;
    h[HDR_TOTLEN_LSB +: 16] = (m.opcode == OP_GET && hit) ? m.vallen : 16'h0000;
    h[HDR_MAGIC_LSB +: 16]  = MAGIC;
    return h;
  endfunction

  // Byte-enable mask with the low nbytes lanes set (nbytes in 1..64)
  function automatic logic [63:0] keep_mask(input logic [6:0] nbytes);
    logic [63:0] m;
    if (nbytes >= 7'd64) begin
      m = '1;
    end else begin
      m = (64'd1 << nbytes) - 64'd1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - single-stage AXI-Stream output register with advance logic
module axis_out_reg #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [KEEP_WIDTH-1:0] load_keep,
  input  logic                  load_last,
  output logic                  adv,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  // The register may take a new beat when it is empty or its beat leaves this cycle
  assign adv = !m_axis_tvalid || m_axis_tready;

  // Load a new beat on advance; otherwise hold the pending beat unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (adv) begin
      m_axis_tvalid <= load;
      if (load) begin
        m_axis_tdata <= load_data;
        m_axis_tkeep <= load_keep;
        m_axis_tlast <= load_last;
      end
    end
  end

endmodule

// File: rtl/kv_response_builder.sv
// rtl/kv_response_builder.sv - merges descriptor, result and value stream into one response packet
module kv_response_builder
  import kv_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int META_WIDTH = 96
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [META_WIDTH-1:0]   s_meta_data,
  input  logic                    s_meta_valid,
  output logic                    s_meta_ready,
  input  logic                    s_res_hit,
  input  logic                    s_res_valid,
  output logic                    s_res_ready,
  input  logic [DATA_WIDTH-1:0]   s_value_data,
  input  logic                    s_value_last,
  input  logic                    s_value_valid,
  output logic                    s_value_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_err_len
);

  localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
  localparam int CARRY_WIDTH = HDR_BYTES * 8;
  localparam int BODY_WIDTH  = DATA_WIDTH - CARRY_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HDR   = 2'd1;
  localparam logic [1:0] VALUE = 2'd2;
  localparam logic [1:0] TAIL  = 2'd3;

  localparam logic [KEEP_WIDTH-1:0] HDR_KEEP = {{(KEEP_WIDTH-HDR_BYTES){1'b0}}, {HDR_BYTES{1'b1}}};

  logic [1:0]             state;
  logic [CARRY_WIDTH-1:0] carry;
  logic [13:0]            beat_cnt;
  logic [13:0]            last_idx;
  logic                   tail_q;
  logic [KEEP_WIDTH-1:0]  last_keep;
  logic                   err_q;

  logic                   adv;
  logic                   load;
  logic [DATA_WIDTH-1:0]  load_data;
  logic [KEEP_WIDTH-1:0]  load_keep;
  logic                   load_last;

  kv_meta_t    meta_in;
  logic        value_pkt_in;
  logic [16:0] in_words;
  logic [16:0] out_words;
  logic [13:0] in_beats;
  logic [13:0] out_beats;
  logic        tail_in;
  logic [19:0] byte_total;
  logic [19:0] byte_m1;
  logic [6:0]  last_bytes;
  logic        accept;
  logic        value_hs;
  logic        counted_last;
  logic        early_last;
  logic        unused_bits;

  // Decode the offered descriptor so everything needed later is latched at acceptance
  assign meta_in      = s_meta_data;
  assign value_pkt_in = (meta_in.opcode == OP_GET) && s_res_hit && (meta_in.vallen != 16'h0000);
  assign in_words     = {1'b0, meta_in.vallen} + 17'd7;
  assign out_words    = {1'b0, meta_in.vallen} + 17'd9;
  assign in_beats     = in_words[16:3];
  assign out_beats    = out_words[16:3];
  assign tail_in      = (out_beats != in_beats);
  assign byte_total   = 20'(HDR_BYTES) + {1'b0, meta_in.vallen, 3'b000};
  assign byte_m1      = byte_total - 20'd1;
  assign last_bytes   = {1'b0, byte_m1[5:0]} + 7'd1;
  assign unused_bits  = ^{meta_in.keylen, OP_SET, in_words[2:0], out_words[2:0], byte_m1[19:6]};

  assign accept        = (state == IDLE) && s_meta_valid && s_res_valid && adv;
  assign s_meta_ready  = accept;
  assign s_res_ready   = accept;
  assign s_value_ready = (state == VALUE) && adv;
  assign value_hs      = s_value_ready && s_value_valid;
  assign counted_last  = (beat_cnt == last_idx);
  assign early_last    = s_value_last && !counted_last;
  assign m_err_len     = err_q;

  // Select the beat offered to the output register for the current state
  always_comb begin
    load      = 1'b0;
    load_data = '0;
    load_keep = '1;
    load_last = 1'b0;
    case (state)
      HDR, TAIL: begin
        load      = adv;
        load_data = {{BODY_WIDTH{1'b0}}, carry};
        load_keep = HDR_KEEP;
        load_last = 1'b1;
      end
      VALUE: begin
        load      = value_hs;
        load_data = {s_value_data[BODY_WIDTH-1:0], carry};
        load_last = early_last || (counted_last && !tail_q);
        load_keep = (counted_last && !tail_q) ? last_keep : '1;
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  // Packet sequencing: latch the request, walk the value beats, emit the tail when needed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      carry     <= '0;
      beat_cnt  <= '0;
      last_idx  <= '0;
      tail_q    <= 1'b0;
      last_keep <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            carry     <= build_header(meta_in, s_res_hit);
            beat_cnt  <= '0;
            last_idx  <= in_beats - 14'd1;
            tail_q    <= tail_in;
            last_keep <= keep_mask(last_bytes);
            state     <= value_pkt_in ? VALUE : HDR;
          end
        end
        HDR: begin
          if (adv) state <= IDLE;
        end
        VALUE: begin
          if (value_hs) begin
            carry    <= s_value_data[DATA_WIDTH-1:BODY_WIDTH];
            beat_cnt <= beat_cnt + 14'd1;
            if (early_last) begin
              err_q <= 1'b1;
              state <= IDLE;
            end else if (counted_last) begin
              err_q <= !s_value_last;
              state <= tail_q ? TAIL : IDLE;
            end
          end
        end
        TAIL: begin
          if (adv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_out (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .load_data     (load_data),
    .load_keep     (load_keep),
    .load_last     (load_last),
    .adv           (adv),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

endmodule

// File: doc/kv_response_builder.md
# kv_response_builder

Response-side counterpart of the KV request parser. It merges one request descriptor (96-bit meta), one lookup/store result and, for GET hits, the value word stream. From these it emits one 512-bit AXI-Stream response packet toward the UDP transmit path. The response uses the same 128-bit header layout as requests, so the value is realigned behind a 16-byte header.

## Interface
Parameters:
- DATA_WIDTH, 512, stream width in bits; only 512 is supported.
- META_WIDTH, 96, descriptor width: [95:88] opcode, [87:80] keylen, [79:64] vallen (64-bit words), [63:0] net_meta.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset: synchronous, active-low; clock clk.
- s_meta_data, in, META_WIDTH, request descriptor.
- s_meta_valid / s_meta_ready, in / out, 1, descriptor handshake.
- s_res_hit, in, 1, 1 means hit/stored, 0 means miss/fail.
- s_res_valid / s_res_ready, in / out, 1, result handshake.
- s_value_data, in, 512, value beats, packed from bit 0, little-endian bytes.
- s_value_last, in, 1, last value beat.
- s_value_valid / s_value_ready, in / out, 1, value handshake.
- m_axis_tdata, out, 512, response data.
- m_axis_tkeep, out, 64, byte enables.
- m_axis_tlast, out, 1, end of packet.
- m_axis_tvalid / m_axis_tready, out / in, 1, output handshake.
- m_err_len, out, 1, one-cycle pulse when s_value_last disagrees with vallen.

## Operation
- Response header fields:
  - [127:64] net_meta
  - [63:56] opcode
  - [55:48] status: 0x00 when hit, 0x01 when miss
  - [47:32] totlen_words: V for a GET hit, otherwise 0
  - [31:16] 0
  - [15:0] 0xFFFF
- V is vallen. A packet carries a value only when opcode==0x02, hit==1 and V!=0. All other cases produce a header-only packet: one beat, tkeep=0xFFFF, tlast=1.
- Realignment rule: output beat k = {in[k][383:0], carry}.
  - carry starts as the header.
  - carry is then updated to in[k][511:384].
- Input beat count is ceil(V/8).
- Output beat count is ceil((V+2)/8). This means one extra tail beat, carrying only the carry, when V mod 8 is 7 or 0.
- On the final beat, tkeep has the low B bits set, where B = ((16+8V-1) mod 64)+1. All other beats have tkeep all ones.
- tlast is derived from the beat counter, not from s_value_last.
- If s_value_last arrives earlier than the counted last beat, that beat is emitted with tlast=1 and full tkeep, m_err_len pulses, and the FSM returns to IDLE.
- If the counted last beat arrives without s_value_last, it still ends the packet and m_err_len pulses.
- State machine:
  - IDLE: wait for meta and result to be valid together. Latch both.
    - Value packet → VALUE.
    - Header-only → HDR.
  - HDR: load the header-only beat → IDLE.
  - VALUE: one output beat per accepted value beat. At the counted last beat:
    - tail needed → TAIL;
    - otherwise → IDLE.
  - TAIL: load {384'b0, carry} with tkeep=0xFFFF → IDLE.
- Field widths:
  - Beat counters are 14 bits.
  - Byte arithmetic is 20 bits.
  - V = 0xFFFF must not overflow any of these.

## Timing
- Reset values: all valids, readys, tlast and m_err_len are 0; tdata and tkeep are 0; state is IDLE.
- Output goes through a single register stage. Let adv = !m_axis_tvalid || m_axis_tready. The register loads only when adv is 1, and tvalid is held until the beat is accepted.
- Descriptor and result acceptance: s_meta_ready = s_res_ready = (state==IDLE) && s_meta_valid && s_res_valid && adv. Both are consumed in the same cycle.
- s_value_ready = (state==VALUE) && adv, which is combinational from state and the output register.
- Latencies:
  - header-only packet appears on the output 2 cycles after acceptance;
  - value packets add 1 cycle per value beat after the input handshake.
- Sustained throughput is 1 beat/clk when m_axis_tready is held high.
- Packets never interleave. A new descriptor is not accepted until the previous packet's last beat has been loaded.
- Back-pressure: all input data is held while m_axis_tready=0, with no loss and no duplication.
- Reset mid-packet: the packet is abandoned with no tlast emitted, and the block is in IDLE on the next cycle.

## Structure
- kv_pkg holds:
  - opcode constants: OP_SET=0x01, OP_GET=0x02
  - status codes
  - header bit offsets and the MAGIC value 0xFFFF
  - HDR_BYTES=16
  - the descriptor field slices, shared with the request parser
- One sub-module is used: axis_out_reg, the single-stage output register with the adv logic.

## Test plan
- SET (0x01), hit=1, net_meta=0x1122334455667788 → one beat: status 0x00, totlen 0, tkeep 0xFFFF, tlast=1.
- GET, hit=0, V=4 → header-only beat with status 0x01 and totlen 0. No value beat is consumed.
- GET hit, V=5 → one beat: tkeep 0x00FF_FFFF_FFFF_FFFF, value word 0 at bits [191:128].
- GET hit, V=8 with one input beat → two beats; the second has tkeep 0xFFFF and carries input bits [511:384].
- GET hit, V=14, random m_axis_tready → two full beats, no loss. Follow with back-to-back header-only requests, which must be accepted no faster than one per two cycles.
- GET hit, V=20 with s_value_last on input beat 2 → tlast on beat 2 and an m_err_len pulse; the next request is processed correctly.
